// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multi-read-port register file with x0 = 0 and a per-register busy scoreboard
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        writeReg,
    input  logic [DATA_W-1:0]        writeData,
    input  logic                     markBusy,
    input  logic [ADDR_W-1:0]        markReg,
    input  logic [NUM_RD*ADDR_W-1:0] readRegs,
    output logic [NUM_RD*DATA_W-1:0] readData,
    output logic [NUM_RD-1:0]        readBusy,
    output logic                     anyBusy
);
    localparam int DEPTH = 2 ** ADDR_W;

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_multiport: NUM_RD must be in 1..4");
    end

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    // The mark is applied after the retire-clear so a new producer issued as the old one retires stays busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            if (RegWrite && writeReg != '0) begin
                regs[writeReg] <= writeData;
            end
            if (RegWrite) begin
                busy[writeReg] <= 1'b0;
            end
            if (markBusy && markReg != '0) begin
                busy[markReg] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;

        assign ra = readRegs[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign hit = RegWrite && (writeReg == ra) && (ra != '0);
`else
        assign hit = 1'b0;
`endif
        assign readData[i*DATA_W +: DATA_W] = (reset || ra == '0) ? '0 :
                                              hit                 ? writeData :
                                                                    regs[ra];
        assign readBusy[i] = !reset && !hit && busy[ra];
    end

    assign anyBusy = !reset && (|busy);

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - self-checking bench for regfile_multiport (vector table, corner sequences, random vs model)
module tb_regfile_multiport;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RegWrite = 1'b0;
    logic [4:0]  writeReg = '0;
    logic [31:0] writeData = '0;
    logic        markBusy = 1'b0;
    logic [4:0]  markReg = '0;
    logic [9:0]  readRegs = '0;
    logic [63:0] readData;
    logic [1:0]  readBusy;
    logic        anyBusy;

    logic         we4 = 1'b0;
    logic [4:0]   wr4 = '0;
    logic [63:0]  wd4 = '0;
    logic         mb4 = 1'b0;
    logic [4:0]   mr4 = '0;
    logic [19:0]  ra4 = '0;
    logic [255:0] rd4;
    logic [3:0]   rb4;
    logic         ab4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_multiport u_dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
        .markBusy(markBusy), .markReg(markReg), .readRegs(readRegs), .readData(readData),
        .readBusy(readBusy), .anyBusy(anyBusy)
    );

    regfile_multiport #(.DATA_W(64), .ADDR_W(5), .NUM_RD(4)) u_dut4 (
        .clk(clk), .reset(reset), .RegWrite(we4), .writeReg(wr4), .writeData(wd4),
        .markBusy(mb4), .markReg(mr4), .readRegs(ra4), .readData(rd4),
        .readBusy(rb4), .anyBusy(ab4)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        mb;
        logic [4:0]  mr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        ea;
    } vec_t;

    vec_t tbl [9];

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    bit          bypass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic mb, input logic [4:0] mr, input logic [4:0] a0, input logic [4:0] a1);
        RegWrite  = we;
        writeReg  = wr;
        writeData = wd;
        markBusy  = mb;
        markReg   = mr;
        readRegs  = {a1, a0};
    endtask

    // Commit the currently driven inputs at one edge, then idle the write/mark controls.
    task automatic commit();
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        markBusy = 1'b0;
        #1;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bypass && RegWrite && writeReg == a) return writeData;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (bypass && RegWrite && writeReg == a) return 1'b0;
        return m_busy[a];
    endfunction

    initial begin
`ifdef REGFILE_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        //             we   wr     wd            mb   mr     ra0    ra1    e0            e1            eb     ea
        tbl[0] = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 2'b00, 1'b0};
        tbl[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 1'b0};
        tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd7,  32'h0,        32'h12345678, 2'b01, 1'b1};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h0,        32'h0,        2'b11, 1'b1};
        tbl[4] = '{1'b1, 5'd9,  32'h000000A5, 1'b0, 5'd0,  5'd9,  5'd0,  32'h000000A5, 32'h0,        2'b00, 1'b0};
        tbl[5] = '{1'b1, 5'd3,  32'h00000055, 1'b1, 5'd3,  5'd3,  5'd9,  32'h00000055, 32'h000000A5, 2'b01, 1'b1};
        tbl[6] = '{1'b1, 5'd3,  32'h00000066, 1'b1, 5'd0,  5'd3,  5'd0,  32'h00000066, 32'h0,        2'b00, 1'b0};
        tbl[7] = '{1'b1, 5'd31, 32'h00000001, 1'b1, 5'd31, 5'd31, 5'd31, 32'h00000001, 32'h00000001, 2'b11, 1'b1};
        tbl[8] = '{1'b1, 5'd31, 32'h00000002, 1'b0, 5'd0,  5'd31, 5'd3,  32'h00000002, 32'h00000066, 2'b00, 1'b0};

        // Reset held: outputs forced to zero even with a write and bypassable read presented.
        drive(1'b1, 5'd4, 32'hCAFEBABE, 1'b1, 5'd4, 5'd4, 5'd4);
        #3;
        chk("reset_rd", readData, 64'd0);
        chk("reset_busy", {62'd0, readBusy}, 64'd0);
        chk("reset_any", {63'd0, anyBusy}, 64'd0);
        #9;
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
        #1;
        chk("reset_discard_x4", readData, 64'd0);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].mb, tbl[i].mr, tbl[i].ra0, tbl[i].ra1);
            commit();
            chk($sformatf("vec%0d_rd0", i), {32'd0, readData[31:0]}, {32'd0, tbl[i].e0});
            chk($sformatf("vec%0d_rd1", i), {32'd0, readData[63:32]}, {32'd0, tbl[i].e1});
            chk($sformatf("vec%0d_busy", i), {62'd0, readBusy}, {62'd0, tbl[i].eb});
            chk($sformatf("vec%0d_any", i), {63'd0, anyBusy}, {63'd0, tbl[i].ea});
        end

        // Same-cycle write/read of a busy register: old value and busy unless forwarding is built in.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd7);
        commit();
        drive(1'b1, 5'd7, 32'h0BADF00D, 1'b0, 5'd0, 5'd7, 5'd7);
        #1;
        chk("pre_edge_rd", readData, bypass ? {2{32'h0BADF00D}} : {2{32'h12345678}});
        chk("pre_edge_busy", {62'd0, readBusy}, bypass ? 64'd0 : 64'd3);
        commit();
        chk("post_edge_rd", readData, {2{32'h0BADF00D}});
        chk("post_edge_busy", {62'd0, readBusy}, 64'd0);

        // Mid-cycle async reset after writing x5, then a write presented under reset is discarded.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd12, 5'd5, 5'd12);
        commit();
        chk("x5_written", {32'd0, readData[31:0]}, 64'h00000000DEADBEEF);
        chk("x12_busy_any", {63'd0, anyBusy}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_rd", readData, 64'd0);
        chk("async_reset_any", {63'd0, anyBusy}, 64'd0);
        drive(1'b1, 5'd6, 32'h00000077, 1'b0, 5'd0, 5'd6, 5'd5);
        @(posedge clk);
        #2;
        reset = 1'b0;
        RegWrite = 1'b0;
        #1;
        chk("write_under_reset", readData, 64'd0);

        // Wide four-port instance: each port returns its own register.
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            we4 = 1'b1;
            wr4 = 5'(i);
            wd4 = 64'h1111_2222_3333_0000 + 64'(i * 64'h0101_0000_0000_0011);
        end
        @(posedge clk);
        #1;
        we4 = 1'b0;
        ra4 = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wide_port%0d", i), rd4[i*64 +: 64],
                64'h1111_2222_3333_0000 + 64'(int'(i + 1) * 64'h0101_0000_0000_0011));
        end
        chk("wide_busy", {60'd0, rb4}, 64'd0);

        // Random traffic from a fresh reset against the array model.
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
        m_busy = 32'd0;
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a0, a1, wr, mr;
            wr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            mr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a0 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 2) == 0) ? mr : 5'($urandom);
            drive(1'($urandom_range(0, 1)), wr, $urandom, 1'($urandom_range(0, 2) == 0), mr, a0, a1);
            #1;
            chk("rand_rd0", {32'd0, readData[31:0]}, {32'd0, exp_rd(a0)});
            chk("rand_rd1", {32'd0, readData[63:32]}, {32'd0, exp_rd(a1)});
            chk("rand_busy", {62'd0, readBusy}, {62'd0, exp_busy(a1), exp_busy(a0)});
            chk("rand_any", {63'd0, anyBusy}, {63'd0, |m_busy});
            @(posedge clk);
            if (RegWrite && writeReg != 5'd0) m_regs[writeReg] = writeData;
            if (RegWrite) m_busy[writeReg] = 1'b0;
            if (markBusy && markReg != 5'd0) m_busy[markReg] = 1'b1;
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
